// File: rtl/fft_stage_ctrl_pkg.sv
// Shared types and constants for the SDF butterfly stage sequencer.
package fft_stage_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_CALC  = 2'd2,
        ST_FLUSH = 2'd3
    } stage_st_t;

    // Output mux select: DIFF comes from the delay line, SUM from bfly dout1
    localparam logic OUT_SEL_DIFF = 1'b0;
    localparam logic OUT_SEL_SUM  = 1'b1;

endpackage

// File: rtl/fft_stage_ctrl_delay_pipe.sv
// W-bit shift register that re-times control bits to the butterfly core's
// output. LAT=0 degenerates to a plain wire.
module fft_stage_ctrl_delay_pipe #(
    parameter int W   = 3,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (LAT == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rstn;
            assign dout = din;
        end else begin : g_reg
            logic [W-1:0] pipe_p [LAT];

            // Shift control bits one stage per cycle; reset discards pipe contents
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int i = 0; i < LAT; i++) pipe_p[i] <= '0;
                end else begin
                    pipe_p[0] <= din;
                    for (int i = 1; i < LAT; i++) pipe_p[i] <= pipe_p[i-1];
                end
            end

            assign dout = pipe_p[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/fft_stage_ctrl.sv
// Sequencer for one radix-2 SDF butterfly stage: beat counter, FILL/CALC/FLUSH
// FSM, delay-line and butterfly strobes, twiddle address and output re-timing.
module fft_stage_ctrl
    import fft_stage_ctrl_pkg::*;
#(
    parameter int NUM       = 16,
    parameter int DATA      = 512,
    parameter int BLK       = DATA / NUM,
    parameter int TW_STRIDE = 1,
    parameter int BFLY_LAT  = 2
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        valid_in,
    input  logic                        sof_in,
    input  logic                        flush_req,
    output logic                        dl_wr_en,
    output logic                        dl_rd_en,
    output logic                        bfly_en,
    output logic                        out_sel,
    output logic [$clog2(DATA/2)-1:0]   tw_addr,
    output logic                        valid_out,
    output logic                        sof_out,
    output logic                        busy,
    output logic                        err_sync
);

    localparam int              HALF    = BLK / 2;
    localparam int              CW      = $clog2(BLK);
    localparam int              TW_W    = $clog2(DATA / 2);
    localparam logic [CW-1:0]   HALF_C  = CW'(HALF);
    localparam logic [CW-1:0]   HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0]   BLK_M1  = CW'(BLK - 1);

    stage_st_t     state;
    logic [CW-1:0] cnt;
    logic          drain_pend;
    logic          frame_first;

    logic          sof_beat;
    logic          realign;
    logic          fill_beat;
    logic          calc_beat;
    logic          flush_cyc;
    logic          flush_ok;
    logic [CW-1:0] idx;
    logic          vld_p0;
    logic          sof_p0;
    logic          sel_p0;
    logic [2:0]    pipe_out;

    // Classify the current cycle. A sof beat outside FLUSH always restarts the
    // frame as FILL beat 0, even when it lands mid-block (realign). A flush
    // request coinciding with an input beat is ignored so no beat is lost.
    always_comb begin
        sof_beat  = valid_in & sof_in & (state != ST_FLUSH);
        realign   = sof_beat & (state != ST_IDLE) & (cnt != '0);
        fill_beat = valid_in & ((state == ST_FILL) | sof_beat);
        calc_beat = valid_in & (state == ST_CALC) & ~sof_in;
        flush_cyc = (state == ST_FLUSH);
        flush_ok  = flush_req & ~valid_in &
                    (((state == ST_FILL) & (cnt == '0)) | ((state == ST_IDLE) & drain_pend));
        idx       = sof_beat ? '0 : cnt;
    end

    // FSM, beat counter and drain bookkeeping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            drain_pend  <= 1'b0;
            frame_first <= 1'b0;
            err_sync    <= 1'b0;
        end else begin
            err_sync <= 1'b0;
            if (fill_beat) begin
                cnt      <= idx + CW'(1);
                state    <= (idx == HALF_M1) ? ST_CALC : ST_FILL;
                err_sync <= realign;
                if (sof_beat) frame_first <= 1'b1;
                // The previous block's differences are fully drained once HALF
                // fill beats have gone by; a realign abandons them.
                if ((idx == HALF_M1) || realign) drain_pend <= 1'b0;
            end else if (calc_beat) begin
                cnt         <= cnt + CW'(1);
                frame_first <= 1'b0;
                if (cnt == BLK_M1) begin
                    state      <= ST_FILL;
                    drain_pend <= 1'b1;
                end
            end else if (flush_cyc) begin
                if (cnt == HALF_M1) begin
                    state      <= ST_IDLE;
                    cnt        <= '0;
                    drain_pend <= 1'b0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else if (flush_ok) begin
                state <= ST_FLUSH;
                cnt   <= '0;
            end
        end
    end

    // Same-cycle datapath strobes, twiddle address and raw output qualifiers
    always_comb begin
        logic [CW-1:0] tw_idx;
        logic [31:0]   tw_full;
        dl_wr_en = fill_beat | calc_beat | flush_cyc;
        dl_rd_en = calc_beat;
        bfly_en  = calc_beat;
        busy     = (state != ST_IDLE);
        tw_idx   = cnt - HALF_C;
        tw_full  = 32'(tw_idx) * 32'(TW_STRIDE);
        tw_addr  = '0;
        if (state == ST_CALC) tw_addr = TW_W'(tw_full % 32'(DATA / 2));
        vld_p0   = calc_beat | (fill_beat & drain_pend & ~realign) | flush_cyc;
        sof_p0   = calc_beat & frame_first;
        sel_p0   = ((state == ST_CALC) & ~sof_beat) ? OUT_SEL_SUM : OUT_SEL_DIFF;
    end

    // ---- stage boundary: align {valid, sof, out_sel} with the bfly core output ----
    fft_stage_ctrl_delay_pipe #(
        .W   (3),
        .LAT (BFLY_LAT)
    ) u_delay_pipe (
        .clk  (clk),
        .rstn (rstn),
        .din  ({vld_p0, sof_p0, sel_p0}),
        .dout (pipe_out)
    );

    assign {valid_out, sof_out, out_sel} = pipe_out;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Testbench for fft_stage_ctrl (BLK=32, HALF=16, BFLY_LAT=2, TW_STRIDE=1).
module tb_fft_stage_ctrl;

    localparam int NUM       = 16;
    localparam int DATA      = 512;
    localparam int BLK       = 32;
    localparam int HALF      = BLK / 2;
    localparam int TW_STRIDE = 1;
    localparam int BFLY_LAT  = 2;
    localparam int TW_W      = $clog2(DATA / 2);

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            valid_in = 1'b0;
    logic            sof_in = 1'b0;
    logic            flush_req = 1'b0;
    logic            dl_wr_en, dl_rd_en, bfly_en, out_sel;
    logic [TW_W-1:0] tw_addr;
    logic            valid_out, sof_out, busy, err_sync;

    fft_stage_ctrl #(
        .NUM(NUM), .DATA(DATA), .BLK(BLK), .TW_STRIDE(TW_STRIDE), .BFLY_LAT(BFLY_LAT)
    ) dut (
        .clk(clk), .rstn(rstn), .valid_in(valid_in), .sof_in(sof_in), .flush_req(flush_req),
        .dl_wr_en(dl_wr_en), .dl_rd_en(dl_rd_en), .bfly_en(bfly_en), .out_sel(out_sel),
        .tw_addr(tw_addr), .valid_out(valid_out), .sof_out(sof_out), .busy(busy),
        .err_sync(err_sync)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        bit sel;
        bit sof;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done = 1'b0;

    // Reference model state: frame position, pending differences, flush countdown
    bit   m_active;
    int   m_pos;
    int   m_drain;
    int   m_flush;
    bit   m_first;
    bit   m_err_exp;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input bit sel, input bit sof);
        exp_t e;
        e.due = cyc + BFLY_LAT;
        e.sel = sel;
        e.sof = sof;
        q.push_back(e);
    endtask

    task automatic model_reset();
        m_active  = 1'b0;
        m_pos     = 0;
        m_drain   = 0;
        m_flush   = 0;
        m_first   = 1'b0;
        m_err_exp = 1'b0;
        q.delete();
    endtask

    // One clock of stimulus with model prediction and strobe checks
    task automatic step(input bit v, input bit s, input bit f);
        bit flushing;
        int b;
        bit e_wr, e_rd, e_bf, e_busy, e_err;
        int e_tw;
        @(negedge clk);
        chk("err_sync", int'(err_sync), int'(m_err_exp));
        valid_in  = v;
        sof_in    = s;
        flush_req = f;
        #1;
        flushing = (m_flush > 0);
        b        = m_pos % BLK;
        e_busy   = m_active || flushing;
        e_tw     = (!flushing && m_active && b >= HALF) ? ((b - HALF) * TW_STRIDE) % (DATA / 2) : 0;
        e_wr = 0; e_rd = 0; e_bf = 0; e_err = 0;
        if (flushing) begin
            e_wr = 1;
            push(1'b0, 1'b0);
            m_flush--;
        end else if (v && s) begin
            e_wr = 1;
            if (m_active && b != 0) begin
                e_err   = 1;
                m_drain = 0;
            end
            if (m_drain > 0) begin
                push(1'b0, 1'b0);
                m_drain--;
            end
            m_active = 1;
            m_pos    = 1;
            m_first  = 1;
        end else if (v && m_active) begin
            if (b < HALF) begin
                e_wr = 1;
                if (m_drain > 0) begin
                    push(1'b0, 1'b0);
                    m_drain--;
                end
            end else begin
                e_wr = 1; e_rd = 1; e_bf = 1;
                push(1'b1, m_first);
                m_first = 0;
                if (b == BLK - 1) m_drain = HALF;
            end
            m_pos++;
        end else if (f && !v && m_active && b == 0) begin
            m_flush  = HALF;
            m_active = 0;
            m_drain  = 0;
        end
        chk("strobes{wr,rd,bf,busy}", int'({dl_wr_en, dl_rd_en, bfly_en, busy}),
            int'({e_wr, e_rd, e_bf, e_busy}));
        chk("tw_addr", int'(tw_addr), e_tw);
        m_err_exp = e_err;
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid_in  = 1'b0;
        sof_in    = 1'b0;
        flush_req = 1'b0;
        rstn      = 1'b0;
        model_reset();
        #1;
        chk("reset_outputs", int'({dl_wr_en, dl_rd_en, bfly_en, out_sel, valid_out, sof_out, busy, err_sync}), 0);
        chk("reset_tw_addr", int'(tw_addr), 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic frame(input int nbeats);
        for (int i = 0; i < nbeats; i++) step(1'b1, i == 0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    // Output monitor: pops the expected stream whenever the DUT presents a beat
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rstn && !done) begin
                if (sof_out && !valid_out) chk("sof_out_without_valid", 1, 0);
                if (valid_out) begin
                    if (q.size() == 0) begin
                        chk("unexpected_valid_out", 1, 0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("valid_out_cycle", cyc, e.due);
                        chk("out_sel", int'(out_sel), int'(e.sel));
                        chk("sof_out", int'(sof_out), int'(e.sof));
                    end
                end else if (q.size() > 0 && q[0].due < cyc) begin
                    chk("missing_valid_out_at", cyc, q[0].due);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        model_reset();
        do_reset();

        // Single block, then flush of its differences
        frame(32);
        idle(3);
        step(1'b0, 1'b0, 1'b1);
        idle(20);

        // Two blocks back to back, then flush
        frame(64);
        step(1'b0, 1'b0, 1'b1);
        idle(20);

        // Alternating valid gaps over one block
        for (int i = 0; i < 64; i++) step(i % 2 == 0, i == 0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        idle(20);

        // sof arriving at beat 10 of a block
        frame(10);
        frame(40);
        idle(4);

        // Flush request where it must be ignored (mid-FILL)
        step(1'b0, 1'b0, 1'b1);
        frame(5);
        step(1'b0, 1'b0, 1'b1);
        idle(3);

        // Reset during CALC beat 20, then a clean frame
        frame(20);
        do_reset();
        frame(32);
        step(1'b0, 1'b0, 1'b1);
        idle(20);

        // Randomized traffic: gaps, occasional sof, occasional flush requests
        frame(1);
        for (int i = 0; i < 3000; i++) begin
            bit v, s, f;
            v = ($urandom % 10) < 7;
            s = v && (($urandom % 45) == 0);
            f = !v && (($urandom % 5) == 0);
            step(v, s, f);
        end
        idle(24);

        @(negedge clk);
        chk("err_sync_final", int'(err_sync), int'(m_err_exp));
        chk("scoreboard_empty", q.size(), 0);
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
